// File: rtl/ws_array_pkg.sv
// Shared definitions for the weight-stationary array controller: PE control
// encodings, controller state encoding and accumulator width derivation.
package ws_array_pkg;

  localparam logic [1:0] PE_HOLD    = 2'b00;
  localparam logic [1:0] PE_LOAD    = 2'b01;
  localparam logic [1:0] PE_COMPUTE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_e;

  function automatic int acc_width(input int word_width);
    return 4 * word_width;
  endfunction

endpackage

// File: rtl/ws_array_controller_skew_buffer.sv
// Diagonal input skew for the array's left edge: lane r passes through r+1
// registered stages that only advance while en is high.
module skew_buffer #(
  parameter int WORD_WIDTH = 8,
  parameter int ARRAY_ROWS = 4
) (
  input  logic                                  clk,
  input  logic                                  clr,
  input  logic                                  en,
  input  logic [ARRAY_ROWS-1:0][WORD_WIDTH-1:0] din,
  output logic [ARRAY_ROWS-1:0][WORD_WIDTH-1:0] dout
);

  for (genvar r = 0; r < ARRAY_ROWS; r++) begin : g_lane
    logic [r:0][WORD_WIDTH-1:0] stg;

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        stg <= '0;
      end else if (en) begin
        stg[0] <= din[r];
        for (int s = 1; s <= r; s++) stg[s] <= stg[s-1];
      end
    end

    assign dout[r] = stg[r];
  end

endmodule

// File: rtl/ws_array_controller.sv
// Sequencer for a weight-stationary systolic array: weight preload, skewed
// activation streaming and pipeline drain, each gated by valid/ready.
module ws_array_controller
  import ws_array_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int ARRAY_ROWS = 4,
  parameter int ARRAY_COLS = 4,
  parameter int VEC_CNT_W  = 8,
  localparam int ACC_W     = acc_width(WORD_WIDTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [VEC_CNT_W-1:0]             num_vecs,
  output logic                             busy,
  output logic                             done,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [ARRAY_COLS*ACC_W-1:0]      w_data,
  input  logic                             a_valid,
  output logic                             a_ready,
  input  logic [ARRAY_ROWS*WORD_WIDTH-1:0] a_data,
  output logic [1:0]                       pe_control,
  output logic [ARRAY_COLS*ACC_W-1:0]      pe_d_in,
  output logic [ARRAY_ROWS*WORD_WIDTH-1:0] pe_a_in
);

  localparam int WCNT_W = $clog2(ARRAY_ROWS + 1);
  localparam int DCNT_W = $clog2(ARRAY_ROWS + ARRAY_COLS);
  localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(ARRAY_ROWS - 1);
  localparam logic [DCNT_W-1:0] D_LAST = DCNT_W'(ARRAY_ROWS + ARRAY_COLS - 2);

  ctrl_state_e state, state_nx;
  logic [WCNT_W-1:0]    wcnt, wcnt_nx;
  logic [VEC_CNT_W-1:0] vcnt, vcnt_nx, nv_q, nv_nx;
  logic [DCNT_W-1:0]    dcnt, dcnt_nx;
  logic [1:0]           action;
  logic                 w_beat, skew_en;
  logic [ARRAY_ROWS-1:0][WORD_WIDTH-1:0] skew_din, skew_dout;

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    vcnt_nx  = vcnt;
    dcnt_nx  = dcnt;
    nv_nx    = nv_q;
    action   = PE_HOLD;
    w_beat   = 1'b0;
    skew_en  = 1'b0;
    skew_din = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (num_vecs != '0) begin
            nv_nx    = num_vecs;
            wcnt_nx  = '0;
            vcnt_nx  = '0;
            dcnt_nx  = '0;
            state_nx = ST_LOAD;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (w_valid) begin
          w_beat  = 1'b1;
          action  = PE_LOAD;
          wcnt_nx = wcnt + WCNT_W'(1);
          if (wcnt == W_LAST) state_nx = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (a_valid) begin
          action   = PE_COMPUTE;
          skew_en  = 1'b1;
          skew_din = a_data;
          vcnt_nx  = vcnt + VEC_CNT_W'(1);
          if (vcnt == nv_q - VEC_CNT_W'(1)) state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // zeros flushed in behind the last vector so every row finishes
        action  = PE_COMPUTE;
        skew_en = 1'b1;
        dcnt_nx = dcnt + DCNT_W'(1);
        if (dcnt == D_LAST) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      wcnt       <= '0;
      vcnt       <= '0;
      dcnt       <= '0;
      nv_q       <= '0;
      pe_control <= PE_HOLD;
      pe_d_in    <= '0;
    end else begin
      state      <= state_nx;
      wcnt       <= wcnt_nx;
      vcnt       <= vcnt_nx;
      dcnt       <= dcnt_nx;
      nv_q       <= nv_nx;
      pe_control <= action;
      pe_d_in    <= w_beat ? w_data : '0;
    end
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign w_ready = (state == ST_LOAD);
  assign a_ready = (state == ST_COMPUTE);

  skew_buffer #(
    .WORD_WIDTH(WORD_WIDTH),
    .ARRAY_ROWS(ARRAY_ROWS)
  ) u_skew (
    .clk (clk),
    .clr (reset),
    .en  (skew_en),
    .din (skew_din),
    .dout(skew_dout)
  );

  assign pe_a_in = skew_dout;

endmodule

// File: tb/tb_ws_array_controller.sv
// Self-checking bench: per run, a timeline of expected outputs is derived from
// the phase rules and the valid patterns, then compared cycle by cycle.
module tb_ws_array_controller;
  import ws_array_pkg::*;

  localparam int W = 8, R = 4, C = 4, VW = 8;
  localparam int ACC = 4 * W, AW = R * W, DW = C * ACC;
  localparam int MAXC = 256, NDRAIN = R + C - 1;

  logic clk = 1'b0;
  logic reset, start, busy, done, w_valid, w_ready, a_valid, a_ready;
  logic [VW-1:0] num_vecs;
  logic [DW-1:0] w_data, pe_d_in;
  logic [AW-1:0] a_data, pe_a_in;
  logic [1:0]    pe_control;

  always #5 clk = ~clk;

  ws_array_controller #(
    .WORD_WIDTH(W), .ARRAY_ROWS(R), .ARRAY_COLS(C), .VEC_CNT_W(VW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_vecs(num_vecs),
    .busy(busy), .done(done), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .pe_control(pe_control), .pe_d_in(pe_d_in), .pe_a_in(pe_a_in)
  );

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".w_ready"}, w_ready, 0);
    chk({tag, ".a_ready"}, a_ready, 0);
    chk({tag, ".ctl"}, pe_control, 0);
    chk({tag, ".d_in"}, pe_d_in, 0);
    chk({tag, ".a_in"}, pe_a_in, 0);
  endtask

  task automatic idle_inputs();
    start = 0; num_vecs = '0; w_valid = 0; a_valid = 0; w_data = '0; a_data = '0;
  endtask

  // mode: 0 random, 1 nominal, 2 nominal+weight stall, 3 nominal+activation
  // stall, 4 random+starts while busy, 5 nominal+starts while busy
  task automatic run(input int mode, input int nv, input int abort_cyc);
    logic          wv[MAXC], av[MAXC], bz_e[MAXC], dn_e[MAXC], wr_e[MAXC], ar_e[MAXC], adv[MAXC];
    logic [DW-1:0] wd[MAXC], d_e[MAXC];
    logic [AW-1:0] ad[MAXC], advd[MAXC];
    logic [1:0]    ctl_e[MAXC];
    logic [AW-1:0] q[$];
    logic [AW-1:0] ae, qe;
    int c, nb, last, n;
    bit nominal, busy_st;
    nominal = (mode == 1 || mode == 2 || mode == 3 || mode == 5);
    busy_st = (mode >= 4);
    for (int i = 0; i < MAXC; i++) begin
      wv[i] = ($urandom_range(99) >= 30);
      av[i] = ($urandom_range(99) >= 30);
      wd[i] = {$urandom, $urandom, $urandom, $urandom};
      ad[i] = $urandom;
      if (nominal) begin
        wv[i] = 1; av[i] = 1; wd[i] = DW'(i + 2); ad[i] = {8'd4, 8'd3, 8'd2, 8'd1};
      end
      if (mode == 3) ad[i] = $urandom;
      ctl_e[i] = PE_HOLD; d_e[i] = '0; advd[i] = '0;
      bz_e[i] = 0; dn_e[i] = 0; wr_e[i] = 0; ar_e[i] = 0; adv[i] = 0;
    end
    if (mode == 2) wv[3] = 0;
    if (mode == 3) begin av[6] = 0; av[7] = 0; end

    c = 1;
    if (nv != 0) begin
      nb = 0;
      while (nb < R && c < MAXC - NDRAIN - 4) begin
        bz_e[c] = 1; wr_e[c] = 1;
        if (wv[c]) begin ctl_e[c+1] = PE_LOAD; d_e[c+1] = wd[c]; nb++; end
        c++;
      end
      nb = 0;
      while (nb < nv && c < MAXC - NDRAIN - 4) begin
        bz_e[c] = 1; ar_e[c] = 1;
        if (av[c]) begin ctl_e[c+1] = PE_COMPUTE; adv[c] = 1; advd[c] = ad[c]; nb++; end
        c++;
      end
      repeat (NDRAIN) begin
        bz_e[c] = 1; ctl_e[c+1] = PE_COMPUTE; adv[c] = 1; advd[c] = '0;
        c++;
      end
    end
    bz_e[c] = 1; dn_e[c] = 1; last = c;

    for (int t = 0; t <= last + 2; t++) begin
      @(posedge clk); #1;
      start    = (t == 0) || (busy_st && t >= 1 && t <= last && $urandom_range(2) == 0);
      num_vecs = (t == 0) ? VW'(nv) : VW'($urandom);
      w_valid  = wv[t]; w_data = wd[t];
      a_valid  = av[t]; a_data = ad[t];
      if (t == abort_cyc) begin
        #2 reset = 1;
        #1 chk_zero($sformatf("rst@%0d", t));
        @(negedge clk);
        reset = 0;
        idle_inputs();
        return;
      end
      @(negedge clk);
      n = q.size();
      for (int r = 0; r < R; r++) begin
        qe = '0;
        if (n - 1 - r >= 0) qe = q[n-1-r];
        ae[r*W +: W] = qe[r*W +: W];
      end
      chk($sformatf("busy@%0d", t), busy, bz_e[t]);
      chk($sformatf("done@%0d", t), done, dn_e[t]);
      chk($sformatf("w_ready@%0d", t), w_ready, wr_e[t]);
      chk($sformatf("a_ready@%0d", t), a_ready, ar_e[t]);
      chk($sformatf("ctl@%0d", t), pe_control, ctl_e[t]);
      chk($sformatf("d_in@%0d", t), pe_d_in, d_e[t]);
      chk($sformatf("a_in@%0d", t), pe_a_in, ae);
      if (adv[t]) q.push_back(advd[t]);
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 0;

    run(1, 2, -1);
    run(2, 2, -1);
    run(3, 4, -1);
    run(1, 0, -1);
    run(5, 2, -1);
    run(4, 3, -1);
    run(1, 2, 5);
    run(1, 2, -1);
    run(0, $urandom_range(1, 10), $urandom_range(1, 12));
    run(1, 2, -1);
    for (int k = 0; k < 12; k++)
      run(($urandom_range(1) == 0) ? 0 : 4, $urandom_range(0, 20), -1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ws_array_controller.md
# ws_array_controller

Sequencer for a weight-stationary systolic array built from `ProcessingElementWS` tiles. It accepts a start command, then drives the array's shared `control`, weight (`d_in`) and activation (`a_in`) edges through three phases: weight preload, activation streaming and pipeline drain. It applies the diagonal input skew and gates every phase with valid/ready handshakes to upstream buffers. It sits between the weight/activation buffers and the array boundary.

## Interface
- `WORD_WIDTH`, 8, activation/weight word width; `ACC_W = 4*WORD_WIDTH` (localparam) is the PE `d_in`/`d_out` width.
- `ARRAY_ROWS`, 4, PE rows; one activation lane per row.
- `ARRAY_COLS`, 4, PE columns; one weight lane per column.
- `VEC_CNT_W`, 8, width of `num_vecs`.
- `clk  in  1  clock, rising edge`
- `reset  in  1  asynchronous, active-high reset`
- `start  in  1  command pulse; sampled only in IDLE`
- `num_vecs  in  VEC_CNT_W  activation vectors to stream; latched on accepted start`
- `busy  out  1  high whenever state != IDLE`
- `done  out  1  one-cycle completion pulse`
- `w_valid  in  1` / `w_ready  out  1`: weight-row handshake.
- `w_data  in  ARRAY_COLS*ACC_W  one weight row per beat`
- `a_valid  in  1` / `a_ready  out  1`: activation-vector handshake.
- `a_data  in  ARRAY_ROWS*WORD_WIDTH  one activation vector per beat; lane r is row r`
- `pe_control  out  2  array control: 00 hold, 01 load, 10 compute`
- `pe_d_in  out  ARRAY_COLS*ACC_W  top-edge d_in bus`
- `pe_a_in  out  ARRAY_ROWS*WORD_WIDTH  left-edge a_in bus, skewed`

## Operation
- **IDLE**
  - All handshake outputs are 0.
  - `start=1` with `num_vecs!=0`: latch `num_vecs`, clear the counters, go to LOAD.
  - `start=1` with `num_vecs==0`: go straight to DONE.
- **LOAD**
  - `w_ready=1`.
  - Each beat (`w_valid&w_ready`) issues action LOAD and registers `w_data` into `pe_d_in`.
  - A cycle with no beat issues action HOLD.
  - After `ARRAY_ROWS` beats, go to COMPUTE.
- **COMPUTE**
  - `a_ready=1`.
  - Each beat issues action COMPUTE and advances the skew lines with `a_data`.
  - A cycle with no beat issues HOLD; skew lines are frozen.
  - After `num_vecs` beats, go to DRAIN.
- **DRAIN**
  - Runs `ARRAY_ROWS+ARRAY_COLS-1` cycles.
  - Each cycle issues COMPUTE and advances the skew lines with zeros.
  - Then go to DONE.
- **DONE**
  - `done=1` for exactly this one cycle.
  - Next state is IDLE.
- **Action registration**
  - Action for cycle N appears on `pe_control` in cycle N+1: HOLD gives 00, LOAD gives 01, COMPUTE gives 10.
  - `pe_d_in` is zero except the cycle after a LOAD beat.
- **Skew**
  - Lane r of `pe_a_in` is delayed r additional cycles behind lane 0, so lane 0 has a latency of 1 and lane r has r+1.
  - Delays count advancing cycles only. A HOLD cycle freezes all skew stages and `pe_a_in` keeps its value.
- **Ignored inputs**
  - `start` while busy is ignored.
  - `w_valid` outside LOAD and `a_valid` outside COMPUTE are ignored.
- **Counters**
  - Weight counter is `$clog2(ARRAY_ROWS+1)` bits.
  - Vector counter is `VEC_CNT_W` bits.
  - Drain counter is `$clog2(ARRAY_ROWS+ARRAY_COLS)` bits.
  - Compares are against the latched terminal values; no wrap is permitted.

## Timing
- **Reset**: asserting `reset` at any time, including mid-LOAD or mid-COMPUTE, immediately forces state IDLE and zeroes all counters, skew stages and outputs (`busy`, `done`, `w_ready`, `a_ready`, `pe_control`, `pe_d_in`, `pe_a_in` = 0).
- **Start latency**: start accepted in cycle T gives `busy=1` and `w_ready=1` in cycle T+1.
- **Phase handover**: the last LOAD beat in cycle L gives `a_ready=1` in L+1. No COMPUTE beat is accepted in the same cycle as the last LOAD beat.
- **Completion**: the last COMPUTE beat in cycle C gives DRAIN in C+1..C+ROWS+COLS-1, `done=1` in C+ROWS+COLS, and `busy=0` in C+ROWS+COLS+1.
- **Throughput**: one beat per cycle; a new start is accepted on the first IDLE cycle after DONE.

## Structure
- **Shared package `ws_array_pkg`**
  - PE control encodings `PE_HOLD=2'b00`, `PE_LOAD=2'b01`, `PE_COMPUTE=2'b10`.
  - Controller state encoding (IDLE, LOAD, COMPUTE, DRAIN, DONE).
  - `ACC_W` derivation.
- **Sub-module `skew_buffer`**
  - Parameterised by `WORD_WIDTH` and `ARRAY_ROWS`.
  - Enable input; lane r has r+1 registered stages.
  - Asynchronous active-high clear.

## Test plan
All scenarios use the default parameters (4x4 array, `WORD_WIDTH=8`).
1. **Reset**: assert `reset` mid-cycle after random activity -> all outputs 0 immediately, and `busy=0`.
2. **Nominal run**
   - Stimulus: `start` at cycle 0 with `num_vecs=2`; weight rows 3, 4, 5, 6 on cycles 1-4; activation vectors {1,2,3,4} on cycles 5-6.
   - Response: `pe_control`=01 in cycles 2-5 and 10 in cycles 6-14; lane 3 value 4 first appears on `pe_a_in` in cycle 9; `done`=1 in cycle 14; `busy`=0 in cycle 15.
3. **Weight stall**: `w_valid` low for one cycle between beats 2 and 3 -> `pe_control`=00 for exactly that cycle, still exactly four 01 cycles, and COMPUTE starts one cycle later.
4. **Activation stall**: `a_valid` low for two cycles mid-stream -> `pe_control`=00 for two cycles, `pe_a_in` held constant, and the skew ordering is preserved afterwards.
5. **Zero length / start while busy**
   - `num_vecs=0` -> `done` in T+1, never `pe_control`=01/10.
   - `start` pulsed during COMPUTE -> ignored; the run completes unchanged.
6. **Reset mid-compute**: `reset` asserted during COMPUTE beat 1 -> IDLE and all outputs zero; a fresh start afterwards reproduces scenario 2 exactly.
